datapath_control_unit: RTL and testbench
========================================

Name: datapath_control_unit

Overview:
- Hardwired Moore sequencer that drives every strobe of the bus-based 32-bit datapath: register out/in enables, PC/MAR/MDR/IR/Y/Z/HI/LO strobes, ALU CONTROL and memory Read/Write.
- Executes fetch, decode and execute T-states for ALU, multiply/divide, load, store, nop and halt.
- Sits beside the datapath; takes IR contents and a memory-ready handshake, and emits one-hot control.

Parameters:
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready in any memory state before entering FAULT.
- CTRL_W, 5, width of the ALU CONTROL output.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Clear  in  1  asynchronous, active-low reset.
- IR  in  32  current instruction: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- mem_ready  in  1  memory access done; sampled in memory T-states.
- run_in  in  1  when low, the sequencer parks in T0 before starting a new fetch.
- PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Cout  out  1 each  datapath strobes.
- Read, Write  out  1 each  memory strobes.
- Rout  out  16  one-hot register-to-bus enable (R0..R15).
- Rin  out  16  one-hot bus-to-register load enable.
- CONTROL  out  CTRL_W  ALU operation select.
- run  out  1  high except in HALT and FAULT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- fault  out  1  sticky; set on memory timeout.

Behaviour:
- Reset (Clear=0): state=T0_IDLE. All outputs 0 except run=1; fault=0; wait counter=0.
- Outputs are pure functions of state and the latched IR fields (Moore, registered state). Exactly one bus driver is active per state.
- Fetch:
  - T0: if run_in=1, assert PCout, MARin, IncPC, Zlowin, then go to T1; else hold with all strobes 0.
  - T1: Zlowout, PCin (first cycle only), Read, MDRin. Stay while mem_ready=0. Go to T2 on mem_ready=1.
  - T2: MDRout, IRin; go to DECODE.
  - DECODE: one cycle, no strobes; opcode latched internally.
- Opcodes:
  - 00000 ld; 00010 st.
  - 00011-01011 ALU ops; CONTROL=opcode.
  - 01111 mul; 10000 div.
  - 11000 nop; 11001 halt.
  - Any other: pulse illegal, return to T0 (treated as nop).
- ALU ops:
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], CONTROL=op, Zlowin.
  - T5: Zlowout, Rin[Ra], then T0. Total 7 cycles from T0.
- mul/div:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], CONTROL=op, Zlowin, Zhighin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, then T0.
- ld:
  - T3: Rout[Rb], Yin.
  - T4: Cout, CONTROL=ADD (00011), Zlowin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; wait for mem_ready.
  - T7: MDRout, Rin[Ra], then T0.
- st:
  - T3–T5 as ld.
  - T6: Rout[Ra], MDRin, Read=0.
  - T7: Write; wait for mem_ready, then T0.
- nop: DECODE goes to T0. halt: DECODE goes to HALT (run=0, all strobes 0); only Clear exits.
- Memory wait:
  - The counter resets on entry to each memory state and increments each cycle mem_ready=0.
  - If it reaches MEM_TIMEOUT, go to FAULT: fault=1, run=0, strobes 0; only Clear exits.
  - mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT counts as success.
- mem_ready outside memory states is ignored.
- Rout/Rin index 0..15 decoded from 4-bit fields; Rb=Ra is legal.
- Clear mid-instruction aborts immediately; no partial strobes after Clear deasserts.

Test Plan:
- Reset, run_in=1, IR=add R1,R2,R3 (0x18918000), mem_ready=1 always.
  - Required: strobe sequence T0..T5 in exactly 7 cycles.
  - Required: CONTROL=00011 in T4, Rout=0x0004 then 0x0008, Rin=0x0002 in T5.
- mul R4,R5 (opcode 01111), mem_ready=1.
  - Required: T5 asserts LOin with Zlowout; T6 asserts HIin with Zhighout.
  - Required: no Rin bit ever set; back in T0 after 8 cycles.
- ld R6 with Rb=R2; mem_ready delayed 3 cycles in T6.
  - Required: Read/MDRin held 4 cycles, then MDRout with Rin=0x0040.
- st R7 with mem_ready never asserted.
  - Required: after 15 wait cycles in T7, fault=1 and run=0; Clear low then high restores T0 with fault=0.
- IR opcode 11111.
  - Required: illegal pulses one cycle; returns to T0.
- IR opcode 11001 (halt).
  - Required: run=0 and all strobes stay 0 for 20 cycles.
- Clear asserted during an ALU op's T4.
  - Required: all outputs 0 immediately; state returns to T0.

Source files
------------

// File: rtl/datapath_control_unit.sv
// Hardwired Moore sequencer for the bus-based 32-bit datapath: fetch, decode and
// execute T-states for ALU, mul/div, load, store, nop and halt, with a memory-wait watchdog.
module datapath_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CTRL_W      = 5
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [31:0]       IR,
    input  logic              mem_ready,
    input  logic              run_in,
    output logic              PCout,
    output logic              IncPC,
    output logic              PCin,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Zlowin,
    output logic              Zhighin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              HIin,
    output logic              LOin,
    output logic              Cout,
    output logic              Read,
    output logic              Write,
    output logic [15:0]       Rout,
    output logic [15:0]       Rin,
    output logic [CTRL_W-1:0] CONTROL,
    output logic              run,
    output logic              illegal,
    output logic              fault
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [4:0] OP_LD     = 5'b00000;
    localparam logic [4:0] OP_ST     = 5'b00010;
    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_ALU_HI = 5'b01011;
    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_DIV    = 5'b10000;
    localparam logic [4:0] OP_NOP    = 5'b11000;
    localparam logic [4:0] OP_HALT   = 5'b11001;

    // S_IDLE is the parked T0: no strobes until run_in lets a fetch start.
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [1:0] {C_ALU, C_MULDIV, C_LOAD, C_STORE} cls_t;

    state_t           state, state_next, end_state;
    cls_t             cls, cls_dec;
    logic [4:0]       opcode, op_q;
    logic [3:0]       ra_q, rb_q, rc_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             exec_op, undefined, mem_wait, timeout;
    logic             unused_ir_low;

    assign opcode        = IR[31:27];
    assign unused_ir_low = ^IR[14:0];

    always_comb begin
        cls_dec = C_ALU;
        exec_op = 1'b1;
        if (opcode == OP_LD)
            cls_dec = C_LOAD;
        else if (opcode == OP_ST)
            cls_dec = C_STORE;
        else if (opcode >= OP_ADD && opcode <= OP_ALU_HI)
            cls_dec = C_ALU;
        else if (opcode == OP_MUL || opcode == OP_DIV)
            cls_dec = C_MULDIV;
        else
            exec_op = 1'b0;
    end

    assign undefined = !exec_op && opcode != OP_NOP && opcode != OP_HALT;

    // The watchdog fires on the last permitted cycle only when memory is still busy.
    assign mem_wait = (state == S_T1) || (state == S_T6 && cls == C_LOAD) ||
                      (state == S_T7 && cls == C_STORE);
    assign timeout  = mem_wait && !mem_ready && (wait_cnt == LAST_WAIT);

    always_comb begin
        state_next = state;
        end_state  = run_in ? S_T0 : S_IDLE;
        case (state)
            S_IDLE: if (run_in) state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1: begin
                if (mem_ready)    state_next = S_T2;
                else if (timeout) state_next = S_FAULT;
            end
            S_T2:   state_next = S_DEC;
            S_DEC: begin
                if (exec_op)                 state_next = S_T3;
                else if (opcode == OP_HALT)  state_next = S_HALT;
                else                         state_next = end_state;
            end
            S_T3:   state_next = S_T4;
            S_T4:   state_next = S_T5;
            S_T5:   state_next = (cls == C_ALU) ? end_state : S_T6;
            S_T6: begin
                case (cls)
                    C_STORE: state_next = S_T7;
                    C_LOAD: begin
                        if (mem_ready)    state_next = S_T7;
                        else if (timeout) state_next = S_FAULT;
                    end
                    default: state_next = end_state;
                endcase
            end
            S_T7: begin
                if (cls != C_STORE || mem_ready) state_next = end_state;
                else if (timeout)                state_next = S_FAULT;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state    <= S_IDLE;
            cls      <= C_ALU;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            state   <= state_next;
            illegal <= (state == S_DEC) && undefined;
            if (state_next != state)
                wait_cnt <= '0;
            else if (mem_wait)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (state == S_DEC) begin
                cls  <= cls_dec;
                op_q <= opcode;
                ra_q <= IR[26:23];
                rb_q <= IR[22:19];
                rc_q <= IR[18:15];
            end
        end
    end

    always_comb begin
        PCout    = 1'b0; IncPC    = 1'b0; PCin  = 1'b0; MARin  = 1'b0;
        MDRin    = 1'b0; MDRout   = 1'b0; IRin  = 1'b0; Yin    = 1'b0;
        Zlowin   = 1'b0; Zhighin  = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        HIin     = 1'b0; LOin     = 1'b0; Cout  = 1'b0; Read   = 1'b0;
        Write    = 1'b0;
        Rout     = '0;
        Rin      = '0;
        CONTROL  = '0;
        run      = 1'b1;
        fault    = 1'b0;
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin    = (wait_cnt == '0);
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Yin  = 1'b1;
                Rout = 16'h1 << ((cls == C_MULDIV) ? ra_q : rb_q);
            end
            S_T4: begin
                Zlowin = 1'b1;
                case (cls)
                    C_ALU: begin
                        Rout    = 16'h1 << rc_q;
                        CONTROL = CTRL_W'(op_q);
                    end
                    C_MULDIV: begin
                        Rout    = 16'h1 << rb_q;
                        CONTROL = CTRL_W'(op_q);
                        Zhighin = 1'b1;
                    end
                    default: begin
                        Cout    = 1'b1;
                        CONTROL = CTRL_W'(OP_ADD);
                    end
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                case (cls)
                    C_ALU:    Rin   = 16'h1 << ra_q;
                    C_MULDIV: LOin  = 1'b1;
                    default:  MARin = 1'b1;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_MULDIV: begin
                        Zhighout = 1'b1; HIin = 1'b1;
                    end
                    C_LOAD: begin
                        Read = 1'b1; MDRin = 1'b1;
                    end
                    C_STORE: begin
                        Rout = 16'h1 << ra_q; MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                if (cls == C_STORE) begin
                    Write = 1'b1;
                end else begin
                    MDRout = 1'b1;
                    Rin    = 16'h1 << ra_q;
                end
            end
            S_HALT:  run = 1'b0;
            S_FAULT: begin
                run   = 1'b0;
                fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Bench for datapath_control_unit: a per-instruction model expands each instruction into
// the expected cycle-by-cycle control trace, which is replayed against the DUT.
module tb_datapath_control_unit;

    localparam int TO = 15;

    localparam int PCOUT = 0, INCPC = 1, PCIN = 2, MARIN = 3, MDRIN = 4, MDROUT = 5,
                   IRIN = 6, YIN = 7, ZLIN = 8, ZHIN = 9, ZLOUT = 10, ZHOUT = 11,
                   HIIN = 12, LOIN = 13, COUT = 14, READ = 15, WRITE = 16;

    logic        Clock = 1'b0, Clear = 1'b1;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0, run_in = 1'b1;
    logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin;
    logic Zlowout, Zhighout, HIin, LOin, Cout, Read, Write, run, illegal, fault;
    logic [15:0] Rout, Rin;
    logic [4:0]  CONTROL;

    always #5 Clock = ~Clock;

    datapath_control_unit #(.MEM_TIMEOUT(TO), .CTRL_W(5)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .mem_ready(mem_ready), .run_in(run_in),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Cout(Cout),
        .Read(Read), .Write(Write), .Rout(Rout), .Rin(Rin), .CONTROL(CONTROL),
        .run(run), .illegal(illegal), .fault(fault)
    );

    typedef struct packed {
        logic [16:0] s;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  ctrl;
        logic        run;
        logic        ill;
        logic        flt;
    } obs_t;

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        logic        ri;
        obs_t        e;
    } rec_t;

    typedef struct {
        logic [31:0] ir;
        int          w1;
        int          w2;
        logic [15:0] rin;
        int          reads;
        int          ills;
    } vec_t;

    rec_t        q[$];
    logic [31:0] cur_ir;
    logic        ill_pending = 1'b0;
    int          errors = 0, checks = 0;
    logic [15:0] rin_or;
    int          reads, ills;
    string       tag;
    vec_t        tbl[13];
    int          ops[16] = '{0, 2, 3, 4, 7, 11, 15, 16, 24, 5, 9, 1, 13, 31, 20, 6};

    function automatic logic [15:0] oh(input int i);
        return (i < 0) ? 16'h0 : (16'h1 << i);
    endfunction

    function automatic logic [16:0] sb(input int i);
        return 17'h1 << i;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] enc(input int op, input int a, input int b, input int c);
        return {5'(op), 4'(a), 4'(b), 4'(c), 15'h0};
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o.s = {Write, Read, Cout, LOin, HIin, Zhighout, Zlowout, Zhighin, Zlowin, Yin,
               IRin, MDRout, MDRin, MARin, PCin, IncPC, PCout};
        o.rout = Rout; o.rin = Rin; o.ctrl = CONTROL;
        o.run = run; o.ill = illegal; o.flt = fault;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o = '0;
        o.run = 1'b1;
        return o;
    endfunction

    task automatic check_obs(input string name, input int step, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got=%h expected=%h", name, step, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic put(input logic [16:0] s, input int ro, input int rn, input logic [4:0] c,
                       input logic mr);
        rec_t r;
        r.ir = cur_ir; r.mr = mr; r.ri = 1'b1;
        r.e.s = s; r.e.rout = oh(ro); r.e.rin = oh(rn); r.e.ctrl = c;
        r.e.run = 1'b1; r.e.ill = ill_pending; r.e.flt = 1'b0;
        ill_pending = 1'b0;
        q.push_back(r);
    endtask

    task automatic put_stop(input logic flt);
        rec_t r;
        r.ir = cur_ir; r.mr = rbit(); r.ri = rbit();
        r.e = '0; r.e.flt = flt;
        q.push_back(r);
    endtask

    // A memory access lasts w busy cycles plus the ready cycle, unless w reaches the timeout.
    task automatic mem_phase(input logic [16:0] s0, input logic [16:0] s, input int w,
                             output bit ok);
        ok = (w < TO);
        for (int k = 0; k < (ok ? w + 1 : TO); k++)
            put((k == 0) ? s0 : s, -1, -1, 5'd0, ok && (k == w));
        if (!ok) repeat (5) put_stop(1'b1);
    endtask

    task automatic gen(input logic [31:0] ir, input int w1, input int w2, input bit park);
        int  op, a, b, c;
        bit  ok, ill;
        cur_ir = ir;
        op = int'(ir[31:27]); a = int'(ir[26:23]); b = int'(ir[22:19]); c = int'(ir[18:15]);
        ill = 1'b0;
        put(sb(PCOUT) | sb(MARIN) | sb(INCPC) | sb(ZLIN), -1, -1, 5'd0, rbit());
        mem_phase(sb(ZLOUT) | sb(READ) | sb(MDRIN) | sb(PCIN), sb(ZLOUT) | sb(READ) | sb(MDRIN),
                  w1, ok);
        if (!ok) return;
        put(sb(MDROUT) | sb(IRIN), -1, -1, 5'd0, rbit());
        put('0, -1, -1, 5'd0, rbit());
        if (op == 0 || op == 2) begin
            put(sb(YIN), b, -1, 5'd0, rbit());
            put(sb(COUT) | sb(ZLIN), -1, -1, 5'd3, rbit());
            put(sb(ZLOUT) | sb(MARIN), -1, -1, 5'd0, rbit());
            if (op == 0) begin
                mem_phase(sb(READ) | sb(MDRIN), sb(READ) | sb(MDRIN), w2, ok);
                if (!ok) return;
                put(sb(MDROUT), -1, a, 5'd0, rbit());
            end else begin
                put(sb(MDRIN), a, -1, 5'd0, rbit());
                mem_phase(sb(WRITE), sb(WRITE), w2, ok);
                if (!ok) return;
            end
        end else if (op >= 3 && op <= 11) begin
            put(sb(YIN), b, -1, 5'd0, rbit());
            put(sb(ZLIN), c, -1, 5'(op), rbit());
            put(sb(ZLOUT), -1, a, 5'd0, rbit());
        end else if (op == 15 || op == 16) begin
            put(sb(YIN), a, -1, 5'd0, rbit());
            put(sb(ZLIN) | sb(ZHIN), b, -1, 5'(op), rbit());
            put(sb(ZLOUT) | sb(LOIN), -1, -1, 5'd0, rbit());
            put(sb(ZHOUT) | sb(HIIN), -1, -1, 5'd0, rbit());
        end else if (op == 25) begin
            repeat (20) put_stop(1'b0);
            return;
        end else begin
            ill = (op != 24);
        end
        ill_pending = ill;
        if (park) begin
            q[q.size()-1].ri = 1'b0;
            put('0, -1, -1, 5'd0, rbit());
        end
    endtask

    task automatic play(input int lim);
        int   n;
        rec_t r;
        obs_t o;
        n = (lim < 0 || lim > q.size()) ? q.size() : lim;
        for (int i = 0; i < n; i++) begin
            r = q.pop_front();
            @(negedge Clock);
            o = cur();
            check_obs(tag, i, o, r.e);
            rin_or |= o.rin;
            reads  += int'(o.s[READ]);
            ills   += int'(o.ill);
            mem_ready = r.mr;
            run_in    = r.ri;
            IR        = r.ir;
        end
    endtask

    task automatic clr();
        Clear = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_obs("reset", 0, cur(), idle_obs());
        q.delete();
        ill_pending = 1'b0;
        @(negedge Clock);
        Clear  = 1'b1;
        run_in = 1'b1;
    endtask

    function automatic vec_t mkv(input logic [31:0] ir, input int w1, input int w2,
                                 input logic [15:0] rin, input int rd, input int il);
        vec_t v;
        v.ir = ir; v.w1 = w1; v.w2 = w2; v.rin = rin; v.reads = rd; v.ills = il;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mkv(32'h18918000,     0,  0, 16'h0002,  1, 0);
        tbl[1]  = mkv(enc(15, 4, 5, 0), 0,  0, 16'h0000,  1, 0);
        tbl[2]  = mkv(enc(16, 9, 10, 0), 0, 0, 16'h0000,  1, 0);
        tbl[3]  = mkv(enc(0, 6, 2, 0),  0,  3, 16'h0040,  5, 0);
        tbl[4]  = mkv(enc(2, 7, 1, 0),  0,  2, 16'h0000,  1, 0);
        tbl[5]  = mkv(enc(24, 0, 0, 0), 0,  0, 16'h0000,  1, 0);
        tbl[6]  = mkv(enc(31, 1, 2, 3), 0,  0, 16'h0000,  1, 1);
        tbl[7]  = mkv(enc(11, 15, 14, 13), 0, 0, 16'h8000, 1, 0);
        tbl[8]  = mkv(enc(3, 5, 6, 7),  14, 0, 16'h0020, 15, 0);
        tbl[9]  = mkv(enc(0, 0, 0, 0),  0, 14, 16'h0001, 16, 0);
        tbl[10] = mkv(enc(4, 3, 3, 3),  0,  0, 16'h0008,  1, 0);
        tbl[11] = mkv(enc(1, 2, 2, 2),  0,  0, 16'h0000,  1, 1);
        tbl[12] = mkv(enc(12, 2, 2, 2), 0,  0, 16'h0000,  1, 1);

        #2;
        clr();

        foreach (tbl[i]) begin
            $sformat(tag, "vec%0d", i);
            gen(tbl[i].ir, tbl[i].w1, tbl[i].w2, 1'b1);
            rin_or = '0; reads = 0; ills = 0;
            play(-1);
            check_int({tag, "_rin"},     int'(rin_or), int'(tbl[i].rin));
            check_int({tag, "_reads"},   reads, tbl[i].reads);
            check_int({tag, "_illegal"}, ills,  tbl[i].ills);
        end

        // Parking: run_in low keeps the sequencer idle between instructions.
        tag = "park";
        gen(enc(5, 2, 3, 4), 0, 0, 1'b1);
        q[q.size()-1].ri = 1'b0;
        for (int k = 0; k < 3; k++) begin
            put('0, -1, -1, 5'd0, rbit());
            if (k < 2) q[q.size()-1].ri = 1'b0;
        end
        play(-1);

        tag = "random";
        for (int i = 0; i < 40; i++) begin
            int op, w1;
            op = ops[$urandom_range(0, 15)];
            w1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : 0;
            gen(enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                w1, $urandom_range(0, 14), (i == 39) ? 1'b1 : rbit());
        end
        play(-1);

        tag = "halt";
        gen(enc(25, 0, 0, 0), 0, 0, 1'b1);
        play(-1);
        check_int("halt_run", int'(run), 0);
        clr();

        tag = "timeout";
        gen(enc(2, 7, 3, 0), 0, 99, 1'b1);
        play(-1);
        check_int("timeout_fault", int'(fault), 1);
        check_int("timeout_run", int'(run), 0);
        clr();
        check_int("cleared_fault", int'(fault), 0);

        tag = "abort";
        gen(32'h18918000, 0, 0, 1'b1);
        play(6);
        #2;
        clr();
        tag = "after_abort";
        gen(32'h18918000, 0, 0, 1'b1);
        rin_or = '0;
        play(-1);
        check_int("after_abort_rin", int'(rin_or), 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
